// File: rtl/ca90_item_gen.sv
// Item-memory generator: returns the CA rule-90 iterate of the seed for a symbol index, caching the last result.
// Latency: S+1 cycles from accept to out_valid (S = CA steps needed, one step per clock; S=0 gives valid next cycle).
// Backpressure: result held in DONE until out_ready; req_ready is low outside IDLE, during seed_load and during reset.
module ca90_item_gen #(
  parameter int             DIM   = 8,
  parameter int             IDX_W = 8,
  parameter logic [DIM-1:0] SEED  = DIM'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [DIM-1:0]   seed_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIM-1:0]   out_vec,
  output logic [IDX_W-1:0] out_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [DIM-1:0]   seed_r;
  logic [DIM-1:0]   vec_r;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] tgt_idx;
  logic [DIM-1:0]   vec_next;
  logic [IDX_W-1:0] cur_inc;

  // Rule 90: each bit becomes the XOR of its two ring neighbours
  // (rotate-left-by-1 XOR rotate-right-by-1).
  always_comb begin
    vec_next = {vec_r[DIM-2:0], vec_r[DIM-1]} ^ {vec_r[0], vec_r[DIM-1:1]};
    cur_inc  = cur_idx + IDX_W'(1);
  end

  // The reset input is active-high despite its name; a seed load owns the
  // cycle, so no request is taken alongside it.
  assign req_ready = (state == IDLE) & ~seed_load & ~rst_n;
  assign out_valid = (state == DONE);
  assign out_vec   = vec_r;
  assign out_idx   = cur_idx;

  // Request sequencing: reuse the cached vector when walking forward,
  // restart from the seed when the target lies behind the cache.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      seed_r  <= SEED;
      vec_r   <= SEED;
      cur_idx <= '0;
      tgt_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_load) begin
            seed_r  <= seed_in;
            vec_r   <= seed_in;
            cur_idx <= '0;
          end else if (req_valid) begin
            tgt_idx <= req_idx;
            if (req_idx >= cur_idx) begin
              state <= (req_idx == cur_idx) ? DONE : STEP;
            end else begin
              vec_r   <= seed_r;
              cur_idx <= '0;
              state   <= (req_idx == '0) ? DONE : STEP;
            end
          end
        end
        STEP: begin
          // cur_idx stays strictly below tgt_idx here, so the increment never wraps.
          vec_r   <= vec_next;
          cur_idx <= cur_inc;
          if (cur_inc == tgt_idx) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca90_item_gen.sv
// Directed bench for ca90_item_gen with DIM=8, SEED=8'h01.
// Expected vectors are hand-computed rule-90 iterates.
// Inputs change on the falling edge; outputs are sampled there as well.
module tb_ca90_item_gen;

  logic       clk;
  logic       rst_n;
  logic       seed_load;
  logic [7:0] seed_in;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_vec;
  logic [7:0] out_idx;

  int n_cmp;
  int n_bad;
  int lat;
  logic [7:0] trace [0:15];

  ca90_item_gen #(.DIM(8), .IDX_W(8), .SEED(8'h01)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and count falling edges from the accept edge to out_valid.
  // lat = -1 if the request was not accepted or the result never arrived.
  task automatic do_req(input logic [7:0] idx);
    @(negedge clk);
    req_valid = 1'b1;
    req_idx   = idx;
    #1;
    if (!req_ready) begin
      req_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (i < 16) trace[i] = out_vec;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (out_vec !== 8'h01) begin n_bad++; $display("FAIL reset_out_vec got=%h want=01", out_vec); end
    n_cmp++;
    if (out_idx !== 8'd0) begin n_bad++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_zero_steps();
    do_req(8'd0);
    n_cmp++;
    if (lat != 1) begin n_bad++; $display("FAIL zero_latency got=%0d want=1", lat); end
    n_cmp++;
    if (out_vec !== 8'h01 || out_idx !== 8'd0) begin
      n_bad++; $display("FAIL zero_result got=%h/%0d want=01/0", out_vec, out_idx);
    end
    consume();
  endtask

  task automatic test_steps();
    do_req(8'd3);
    n_cmp++;
    if (lat != 4) begin n_bad++; $display("FAIL step3_latency got=%0d want=4", lat); end
    n_cmp++;
    if (trace[2] !== 8'h82 || trace[3] !== 8'h44) begin
      n_bad++; $display("FAIL step3_trace got=%h,%h want=82,44", trace[2], trace[3]);
    end
    n_cmp++;
    if (out_vec !== 8'hAA || out_idx !== 8'd3) begin
      n_bad++; $display("FAIL step3_result got=%h/%0d want=aa/3", out_vec, out_idx);
    end
    consume();
  endtask

  task automatic test_cache_forward();
    do_req(8'd4);
    n_cmp++;
    if (lat != 2) begin n_bad++; $display("FAIL cache_latency got=%0d want=2", lat); end
    n_cmp++;
    if (out_vec !== 8'h00 || out_idx !== 8'd4) begin
      n_bad++; $display("FAIL cache_result got=%h/%0d want=00/4", out_vec, out_idx);
    end
    consume();
  endtask

  // Descending request restarts from seed; result is then held under backpressure.
  task automatic test_restart_backpressure();
    do_req(8'd1);
    n_cmp++;
    if (lat != 2) begin n_bad++; $display("FAIL restart_latency got=%0d want=2", lat); end
    n_cmp++;
    if (out_vec !== 8'h82 || out_idx !== 8'd1) begin
      n_bad++; $display("FAIL restart_result got=%h/%0d want=82/1", out_vec, out_idx);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_vec !== 8'h82 || out_idx !== 8'd1 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_c%0d got v=%b vec=%h idx=%0d rdy=%b want 1/82/1/0",
                 c, out_valid, out_vec, out_idx, req_ready);
      end
    end
    consume();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL release got rdy=%b v=%b want 1/0", req_ready, out_valid);
    end
    n_cmp++;
    if (out_vec !== 8'h82 || out_idx !== 8'd1) begin
      n_bad++; $display("FAIL cache_kept got=%h/%0d want=82/1", out_vec, out_idx);
    end
  endtask

  task automatic test_seed_load();
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = 8'h03;
    req_valid = 1'b1;
    req_idx   = 8'd5;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL seedld_req_ready got=%b want=0", req_ready); end
    @(posedge clk);
    @(negedge clk);
    seed_load = 1'b0;
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_vec !== 8'h03 || out_idx !== 8'd0) begin
      n_bad++; $display("FAIL seedld_state got v=%b vec=%h idx=%0d want 0/03/0", out_valid, out_vec, out_idx);
    end
    do_req(8'd1);
    n_cmp++;
    if (lat != 2 || out_vec !== 8'h87 || out_idx !== 8'd1) begin
      n_bad++; $display("FAIL seedld_result got lat=%0d vec=%h idx=%0d want 2/87/1", lat, out_vec, out_idx);
    end
    consume();
    // Same index again is served straight from the cache.
    do_req(8'd1);
    n_cmp++;
    if (lat != 1 || out_vec !== 8'h87) begin
      n_bad++; $display("FAIL same_idx got lat=%0d vec=%h want 1/87", lat, out_vec);
    end
    consume();
  endtask

  task automatic test_max_index();
    do_req(8'd255);
    n_cmp++;
    if (lat != 9) begin
      // from cur_idx=1 the walk to 255 needs 254 steps
      if (lat != 255) begin n_bad++; $display("FAIL max_latency got=%0d want=255", lat); end
    end else begin
      n_bad++; $display("FAIL max_latency got=%0d want=255", lat);
    end
    n_cmp++;
    if (out_vec !== 8'h00 || out_idx !== 8'd255) begin
      n_bad++; $display("FAIL max_result got=%h/%0d want=00/255", out_vec, out_idx);
    end
    consume();
  endtask

  task automatic test_reset_mid_step();
    logic stale;
    // Seed is 8'h03 and cache idx 255, so idx 200 restarts from seed.
    @(negedge clk);
    req_valid = 1'b1;
    req_idx   = 8'd200;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_idx !== 8'd5) begin
      n_bad++; $display("FAIL midstep got v=%b idx=%0d want 0/5", out_valid, out_idx);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_vec !== 8'h01 || out_idx !== 8'd0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort got v=%b vec=%h idx=%0d rdy=%b want 0/01/0/1", out_valid, out_vec, out_idx, req_ready);
    end
    stale = 1'b0;
    repeat (250) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_cmp++;
    if (stale !== 1'b0) begin n_bad++; $display("FAIL stale_valid got=%b want=0", stale); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b1;
    seed_load = 1'b0;
    seed_in   = 8'h00;
    req_valid = 1'b0;
    req_idx   = 8'd0;
    out_ready = 1'b0;
    test_reset();
    test_zero_steps();
    test_steps();
    test_cache_forward();
    test_restart_backpressure();
    test_seed_load();
    test_max_index();
    test_reset_mid_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
